// File: rtl/bingo_pkg.sv
// rtl/bingo_pkg.sv - shared types for the Bingo prefetcher and its issue queue
// Purpose: word type, issue-queue entry layout, default block offset and
//          the history table selector used by the prefetcher.
// Ports:   none (package).
package bingo_pkg;

  localparam int WORD_WIDTH           = 64;
  localparam int BLOCK_OFFSET_DEFAULT = 6;

  typedef logic [WORD_WIDTH-1:0] bingo_word;

  // blk holds the block number zero-extended to a full word, so queues
  // built with a narrower WIDTH reuse the same entry layout.
  typedef struct packed {
    bingo_word blk;
    logic      live;
  } pf_queue_entry_t;

  typedef enum logic [1:0] {
    TABLE_PC_ADDRESS = 2'd0,
    TABLE_PC_OFFSET  = 2'd1,
    TABLE_ADDRESS    = 2'd2,
    TABLE_OFFSET     = 2'd3
  } table_type;

endpackage

// File: rtl/bingo_blk_match.sv
// rtl/bingo_blk_match.sv - DEPTH-way block-number compare against queue slots
// Purpose: flags every occupied, live slot whose block number equals key.
// Ports:
//   key       in   block number to look for
//   entries   in   queue slot contents
//   occupied  in   per-slot occupancy mask (between head and tail)
//   match     out  per-slot hit vector
module bingo_blk_match
  import bingo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  bingo_word        key,
  input  pf_queue_entry_t  entries [DEPTH],
  input  logic [DEPTH-1:0] occupied,
  output logic [DEPTH-1:0] match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = occupied[i] && entries[i].live && (entries[i].blk == key);
    end
  end

endmodule

// File: rtl/bingo_pf_issue_queue.sv
// rtl/bingo_pf_issue_queue.sv - prefetch issue queue between Bingo and the lower-level cache
// Purpose: circular FIFO of block-aligned prefetches with duplicate filtering,
//          demand-miss cancellation and a registered valid/ready issue port.
//          WIDTH must not exceed the bingo_word width.
// Optional: define BINGO_PF_QUEUE_STATS_EN to add saturating event counters.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pf_addr_i/pf_valid_i  prefetch request, one per cycle, no backpressure
//   demand_addr_i/_valid_i demand miss that cancels matching queued blocks
//   lo_req_addr_o/_valid_o/lo_req_ready_i  issue handshake to lower level
//   count_o               live entries; full_o all slots occupied
//   drop_o                pulse the cycle after a request was discarded
//   stat_*_o              (stats build only) issued, dropped full/dup, cancelled
module bingo_pf_issue_queue
  import bingo_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 8,
  parameter int BLOCK_OFFSET = BLOCK_OFFSET_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       pf_addr_i,
  input  logic                   pf_valid_i,
  input  logic [WIDTH-1:0]       demand_addr_i,
  input  logic                   demand_valid_i,
  output logic [WIDTH-1:0]       lo_req_addr_o,
  output logic                   lo_req_valid_o,
  input  logic                   lo_req_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
`ifdef BINGO_PF_QUEUE_STATS_EN
  output logic                   drop_o,
  output logic [31:0]            stat_issued_o,
  output logic [31:0]            stat_dropped_full_o,
  output logic [31:0]            stat_dropped_dup_o,
  output logic [31:0]            stat_cancelled_o
`else
  output logic                   drop_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int BLK_W = WIDTH - BLOCK_OFFSET;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   head, tail, head_n, tail_n;
  logic [PTR_W:0]   occupancy, occ_n;
  logic [PTR_W-1:0] head_idx, tail_idx;
  pf_queue_entry_t  entries   [DEPTH];
  pf_queue_entry_t  entries_n [DEPTH];
  logic [PTR_W-1:0] slot_off  [DEPTH];

  logic [DEPTH-1:0] occupied, dup_match, cancel_match, cancel_clear, head_mask;
  bingo_word        pf_blk, demand_blk;
  logic             valid_q, valid_n, drop_q, drop_n;
  logic [WIDTH-1:0] addr_q, addr_n;
  logic             pop, retire, free, full, dup, accept;
  logic [PTR_W:0]   live_count;

  assign head_idx  = head[PTR_W-1:0];
  assign tail_idx  = tail[PTR_W-1:0];
  assign occupancy = tail - head;
  assign full      = (occupancy == (PTR_W+1)'(DEPTH));

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_occ
      assign slot_off[g] = PTR_W'(g) - head_idx;
      assign occupied[g] = ({1'b0, slot_off[g]} < occupancy);
    end
  endgenerate

  assign pf_blk     = bingo_word'(pf_addr_i >> BLOCK_OFFSET);
  assign demand_blk = bingo_word'(demand_addr_i >> BLOCK_OFFSET);

  bingo_blk_match #(.DEPTH(DEPTH)) u_dup_match (
    .key      (pf_blk),
    .entries  (entries),
    .occupied (occupied),
    .match    (dup_match)
  );

  bingo_blk_match #(.DEPTH(DEPTH)) u_cancel_match (
    .key      (demand_blk),
    .entries  (entries),
    .occupied (occupied),
    .match    (cancel_match)
  );

  // A presented head must stay stable, so it is shielded from cancellation.
  always_comb begin
    head_mask           = '0;
    head_mask[head_idx] = valid_q;
  end

  assign cancel_clear = demand_valid_i ? (cancel_match & ~head_mask) : '0;

  // Cancellation is resolved before the duplicate check, so a block being
  // cancelled this cycle can be re-queued by a same-cycle prefetch.
  assign dup    = |(dup_match & ~cancel_clear);
  assign pop    = valid_q && lo_req_ready_i;
  // With nothing presented, a non-empty queue always has a dead head.
  assign retire = !valid_q && (occupancy != '0) && !entries[head_idx].live;
  assign free   = pop || retire;
  assign accept = pf_valid_i && !dup && (!full || free);
  assign drop_n = pf_valid_i && !accept;

  always_comb begin
    entries_n = entries;
    for (int i = 0; i < DEPTH; i++) begin
      if (cancel_clear[i]) begin
        entries_n[i].live = 1'b0;
      end
    end
    if (free) begin
      entries_n[head_idx].live = 1'b0;
    end
    // Written after the free so a push into a just-freed full slot wins.
    if (accept) begin
      entries_n[tail_idx] = '{blk: pf_blk, live: 1'b1};
    end
    head_n = head + (PTR_W+1)'(free);
    tail_n = tail + (PTR_W+1)'(accept);
    occ_n  = tail_n - head_n;

    // Output registers are loaded from the next-cycle head, which gives
    // one-cycle push-to-issue latency and back-to-back issue.
    if (valid_q && !lo_req_ready_i) begin
      valid_n = 1'b1;
      addr_n  = addr_q;
    end else begin
      valid_n = (occ_n != '0) && entries_n[head_n[PTR_W-1:0]].live;
      addr_n  = valid_n ? {entries_n[head_n[PTR_W-1:0]].blk[BLK_W-1:0], {BLOCK_OFFSET{1'b0}}}
                        : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      head    <= head_n;
      tail    <= tail_n;
      valid_q <= valid_n;
      addr_q  <= addr_n;
      drop_q  <= drop_n;
      entries <= entries_n;
    end
  end

  always_comb begin
    live_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_count = live_count + (PTR_W+1)'(occupied[i] && entries[i].live);
    end
  end

  assign count_o        = live_count;
  assign full_o         = full;
  assign drop_o         = drop_q;
  assign lo_req_valid_o = valid_q;
  assign lo_req_addr_o  = addr_q;

`ifdef BINGO_PF_QUEUE_STATS_EN
  logic [31:0] issued_cnt, drop_full_cnt, drop_dup_cnt, cancel_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt    <= '0;
      drop_full_cnt <= '0;
      drop_dup_cnt  <= '0;
      cancel_cnt    <= '0;
    end else begin
      if (pop && (issued_cnt != '1)) begin
        issued_cnt <= issued_cnt + 32'd1;
      end
      if (pf_valid_i && !dup && !accept && (drop_full_cnt != '1)) begin
        drop_full_cnt <= drop_full_cnt + 32'd1;
      end
      if (pf_valid_i && dup && (drop_dup_cnt != '1)) begin
        drop_dup_cnt <= drop_dup_cnt + 32'd1;
      end
      if ((|cancel_clear) && (cancel_cnt != '1)) begin
        cancel_cnt <= cancel_cnt + 32'd1;
      end
    end
  end

  assign stat_issued_o       = issued_cnt;
  assign stat_dropped_full_o = drop_full_cnt;
  assign stat_dropped_dup_o  = drop_dup_cnt;
  assign stat_cancelled_o    = cancel_cnt;
`else
`endif

endmodule
